// File: rtl/steer_pkg.sv
// Shared widths, FSM encoding and saturation helper
// for the steering PID controller.
package steer_pkg;

  localparam int ERR_W = 10;
  localparam int INT_W = 15;
  localparam int DRV_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    TERMS,
    SUM,
    DRIVE
  } state_t;

  function automatic int sat_signed(
    input int value,
    input int width
  );
    int hi;
    int lo;
    hi = (1 <<< (width - 1)) - 1;
    lo = -(1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/steer_pid_sat_drive.sv
// Base speed plus or minus correction,
// clamped to a signed drive word.
module sat_drive
  import steer_pkg::*;
(
  input  logic [10:0] spd,
  input  logic [16:0] corr,
  input  logic        inv,
  output logic [11:0] drv
);

  int sum;

  always_comb begin
    if (inv)
      sum = int'(spd) - int'($signed(corr));
    else
      sum = int'(spd) + int'($signed(corr));
    drv = DRV_W'(sat_signed(sum, DRV_W));
  end

endmodule

// File: rtl/steer_pid.sv
// Multi-cycle saturating PID steering stage
// producing lft/rht drive words.
module steer_pid
  import steer_pkg::*;
#(
  parameter logic [3:0] P_COEF  = 4'd3,
  parameter logic [3:0] D_COEF  = 4'd2,
  parameter int         I_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [11:0] error,
  input  logic        err_vld,
  input  logic [10:0] fwd_spd,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        out_vld,
  output logic        busy
);

  state_t state;

  logic signed [ERR_W-1:0] err_sat;
  logic signed [ERR_W-1:0] prev_err;
  logic signed [ERR_W-1:0] err_nxt;
  logic signed [INT_W-1:0] integ;
  logic signed [INT_W-1:0] int_nxt;
  logic signed [13:0]      p_term;
  logic signed [13:0]      p_nxt;
  logic signed [INT_W-1:0] i_term;
  logic signed [INT_W-1:0] i_nxt;
  logic signed [15:0]      d_term;
  logic signed [15:0]      d_nxt;
  logic signed [16:0]      corr;
  logic signed [16:0]      corr_nxt;
  logic [10:0]             spd;
  logic [11:0]             lft_nxt;
  logic [11:0]             rht_nxt;

  always_comb begin
    err_nxt = ERR_W'(sat_signed(
      int'($signed(error)), ERR_W));
    int_nxt = INT_W'(sat_signed(
      int'(integ) + int'(err_sat), INT_W));
    p_nxt = 14'(int'(err_sat) * int'(P_COEF));
    // I term uses the integrator value being written this cycle
    i_nxt = int_nxt >>> I_SHIFT;
    d_nxt = 16'((int'(err_sat) - int'(prev_err))
      * int'(D_COEF));
    corr_nxt = 17'(int'(p_term) + int'(i_term)
      + int'(d_term));
  end

  sat_drive u_lft (
    .spd  (spd),
    .corr (corr),
    .inv  (1'b0),
    .drv  (lft_nxt)
  );

  sat_drive u_rht (
    .spd  (spd),
    .corr (corr),
    .inv  (1'b1),
    .drv  (rht_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      err_sat  <= '0;
      prev_err <= '0;
      integ    <= '0;
      p_term   <= '0;
      i_term   <= '0;
      d_term   <= '0;
      corr     <= '0;
      spd      <= '0;
      lft      <= '0;
      rht      <= '0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
    end else if (!go) begin
      state    <= IDLE;
      err_sat  <= '0;
      prev_err <= '0;
      integ    <= '0;
      p_term   <= '0;
      i_term   <= '0;
      d_term   <= '0;
      corr     <= '0;
      spd      <= '0;
      lft      <= '0;
      rht      <= '0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (err_vld) begin
            err_sat <= err_nxt;
            spd     <= fwd_spd;
            busy    <= 1'b1;
            state   <= TERMS;
          end
        end
        TERMS: begin
          integ    <= int_nxt;
          p_term   <= p_nxt;
          i_term   <= i_nxt;
          d_term   <= d_nxt;
          prev_err <= err_sat;
          state    <= SUM;
        end
        SUM: begin
          corr  <= corr_nxt;
          state <= DRIVE;
        end
        DRIVE: begin
          lft     <= lft_nxt;
          rht     <= rht_nxt;
          out_vld <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_steer_pid.sv
// Scoreboard bench for steer_pid: directed samples
// with hand-computed drive words and latency.
module tb_steer_pid;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [11:0] error;
  logic        err_vld;
  logic [10:0] fwd_spd;
  logic [11:0] lft;
  logic [11:0] rht;
  logic        out_vld;
  logic        busy;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   vld_cnt;

  steer_pid dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .error   (error),
    .err_vld (err_vld),
    .fwd_spd (fwd_spd),
    .lft     (lft),
    .rht     (rht),
    .out_vld (out_vld),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string name,
    input int    act,
    input int    req
  );
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d",
        name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (out_vld) begin
      exp_t e;
      vld_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_vld actual 1 required 0");
      end else begin
        e = q.pop_front();
        chk("lft", int'($signed(lft)), int'($signed(e.l)));
        chk("rht", int'($signed(rht)), int'($signed(e.r)));
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(
    input logic [11:0] e,
    input logic [10:0] s
  );
    error   = e;
    fwd_spd = s;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
  endtask

  task automatic expect_sample(
    input logic [11:0] e,
    input logic [10:0] s,
    input int          l,
    input int          r
  );
    exp_t x;
    @(negedge clk);
    x.l   = 12'(l);
    x.r   = 12'(r);
    x.due = cyc + 4;
    q.push_back(x);
    issue(e, s);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual %0d required 0",
        q.size());
      q.delete();
    end
  endtask

  initial begin
    int v0;
    checks  = 0;
    errors  = 0;
    vld_cnt = 0;
    rst_n   = 1'b0;
    go      = 1'b0;
    error   = '0;
    err_vld = 1'b0;
    fwd_spd = '0;
    #12;
    chk("rst_lft", int'(lft), 0);
    chk("rst_rht", int'(rht), 0);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    go    = 1'b1;

    expect_sample(12'd100, 11'd512, 1018, 6);
    chk("busy_terms", int'(busy), 1);
    wait_done();

    expect_sample(12'd100, 11'd512, 824, 200);
    wait_done();

    // async reset mid-computation, checked between edges
    @(negedge clk);
    issue(12'd50, 11'd300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_lft", int'(lft), 0);
    chk("async_rht", int'(rht), 0);
    chk("async_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    do_reset();
    expect_sample(12'h7FF, 11'd2047, 2047, -539);
    wait_done();

    do_reset();
    expect_sample(12'h800, 11'd0, -2048, 2047);
    wait_done();

    // go drop during SUM after a non-zero output
    do_reset();
    expect_sample(12'd100, 11'd512, 1018, 6);
    wait_done();
    v0 = vld_cnt;
    @(negedge clk);
    issue(12'd100, 11'd512);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("go_lft", int'(lft), 0);
    chk("go_rht", int'(rht), 0);
    chk("go_busy", int'(busy), 0);
    go = 1'b1;
    repeat (4) @(negedge clk);
    chk("go_no_vld", vld_cnt - v0, 0);
    expect_sample(12'd100, 11'd512, 1018, 6);
    wait_done();

    // sample offered while busy must be dropped
    do_reset();
    v0 = vld_cnt;
    expect_sample(12'd100, 11'd512, 1018, 6);
    error   = 12'hED4;
    fwd_spd = 11'd100;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    chk("single_vld", vld_cnt - v0, 1);
    chk("idle_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
